// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: ping-pong scanline prefetcher for sprite channels over Avalon-MM; define SPRITE_FETCH_MIRROR_EN for word-granular horizontal flip
module sprite_line_fetcher #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 32,
  parameter int CHANNELS       = 2,
  parameter int WORDS_PER_LINE = 16,
  parameter int SPRITE_H       = 32,
  parameter int MAX_PENDING    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IW = $clog2(WORDS_PER_LINE)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       line_start,
  input  logic [10:0]                line_y,
  input  logic [CHANNELS-1:0]        ch_enable,
  input  logic [CHANNELS*ADDR_W-1:0] ch_base,
  input  logic [CHANNELS*11-1:0]     ch_y,
  input  logic [CHANNELS-1:0]        ch_mirror,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_chipselect,
  output logic                       avm_read_n,
  output logic                       avm_write_n,
  output logic [DATA_W/8-1:0]        avm_byteenable_n,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  input  logic                       avm_waitrequest,
  input  logic [CW-1:0]              rd_ch,
  input  logic [IW-1:0]              rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       overrun
);
  localparam int DEPTH = 2*CHANNELS*WORDS_PER_LINE;
  localparam int AW = $clog2(DEPTH);
  localparam int VW = $clog2(2*CHANNELS);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, NEXT, ABORT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [IW-1:0] i_q, i_d, w_q, w_d, wi;
  logic [10:0] row_q, row_d, ny_q, ny_d, cy, row;
  logic [3:0] pend_q, pend_d;
  logic disp_q, disp_d, ovr_q, ovr_d, rdv_q, rdv_d;
  logic [2*CHANNELS-1:0] val_q, val_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS*ADDR_W-1:0] base_q, base_d;
  logic [CHANNELS*11-1:0] y_q, y_d;
  logic [DATA_W-1:0] rdd_q, rdd_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, ret, we, hit;
  int wh_off, rh_off;
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
  assign rd_data = rdd_q;
  assign rd_valid = rdv_q;
  assign avm_write_n = 1'b1;
  assign avm_byteenable_n = '0;
  assign avm_read_n = !(state_q == ISSUE && pend_q < 4'(MAX_PENDING));
  assign avm_chipselect = !avm_read_n;
  assign avm_address = avm_read_n ? '0 :
    base_q[c_q*ADDR_W +: ADDR_W] + (ADDR_W'(row_q) << IW) + ADDR_W'(i_q);
  assign acc = !avm_read_n && !avm_waitrequest;
  assign ret = avm_readdatavalid && pend_q != 4'd0;
  assign we = ret && (state_q == ISSUE || state_q == DRAIN) && !line_start;
  assign cy = y_q[c_q*11 +: 11];
  assign row = ny_q - cy;
  assign hit = en_q[c_q] && ny_q >= cy && row < 11'(SPRITE_H);
  assign wh_off = disp_q ? 0 : CHANNELS;
  assign rh_off = disp_q ? CHANNELS : 0;
`ifdef SPRITE_FETCH_MIRROR_EN
  logic [CHANNELS-1:0] mir_q, mir_d;
  assign mir_d = line_start ? ch_mirror : mir_q;
  assign wi = mir_q[c_q] ? ~w_q : w_q;
  // mirror flags are captured with the rest of the channel setup
  always_ff @(posedge Clk) mir_q <= Reset ? '0 : mir_d;
`else
  logic unused_mir;
  assign unused_mir = ^ch_mirror;
  assign wi = w_q;
`endif
  // next-state: line swap/latch on line_start, otherwise the per-channel fetch FSM
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    i_d = acc ? i_q + 1'b1 : i_q;
    w_d = we ? w_q + 1'b1 : w_q;
    row_d = row_q;
    ny_d = ny_q;
    disp_d = disp_q;
    val_d = val_q;
    en_d = en_q;
    base_d = base_q;
    y_d = y_q;
    pend_d = pend_q + {3'b0, acc} - {3'b0, ret};
    ovr_d = line_start && busy;
    rdv_d = int'(rd_ch) < CHANNELS && val_q[VW'(rh_off + int'(rd_ch))];
    rdd_d = rdv_d ? mem[AW'((rh_off + int'(rd_ch))*WORDS_PER_LINE + int'(rd_idx))] : '0;
    if (line_start) begin
      disp_d = ~disp_q;
      val_d[disp_q*CHANNELS +: CHANNELS] = '0;
      en_d = ch_enable;
      base_d = ch_base;
      y_d = ch_y;
      ny_d = line_y + 11'd1;
      c_d = '0;
      state_d = busy ? ABORT : SETUP;
    end else begin
      case (state_q)
        SETUP: begin
          i_d = '0;
          w_d = '0;
          row_d = row;
          state_d = hit ? ISSUE : NEXT;
        end
        ISSUE: state_d = (acc && i_q == IW'(WORDS_PER_LINE-1)) ? DRAIN : ISSUE;
        DRAIN: if (pend_q == 4'd0) begin
          val_d[VW'(wh_off + int'(c_q))] = 1'b1;
          state_d = NEXT;
        end
        NEXT: begin
          c_d = c_q + 1'b1;
          state_d = (c_q == CW'(CHANNELS-1)) ? IDLE : SETUP;
        end
        ABORT: state_d = (pend_q == 4'd0) ? SETUP : ABORT;
        default: state_d = state_q;
      endcase
    end
  end
  // state register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      c_q <= '0;
      i_q <= '0;
      w_q <= '0;
      row_q <= '0;
      ny_q <= '0;
      pend_q <= '0;
      disp_q <= 1'b0;
      ovr_q <= 1'b0;
      val_q <= '0;
      en_q <= '0;
      base_q <= '0;
      y_q <= '0;
      rdd_q <= '0;
      rdv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      i_q <= i_d;
      w_q <= w_d;
      row_q <= row_d;
      ny_q <= ny_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      ovr_q <= ovr_d;
      val_q <= val_d;
      en_q <= en_d;
      base_q <= base_d;
      y_q <= y_d;
      rdd_q <= rdd_d;
      rdv_q <= rdv_d;
    end
  end
  // returned words land in the write half; validity is tracked separately so no reset is needed
  always_ff @(posedge Clk) if (we && !Reset) mem[AW'((wh_off + int'(c_q))*WORDS_PER_LINE + int'(wi))] <= avm_readdata;
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher: scoreboard bench with an SDRAM model returning address as data
`timescale 1ns/1ps
module tb_sprite_line_fetcher;
  localparam int AW = 25, DW = 32, NC = 2, MAXP = 4, LAT = 5;
  logic Clk = 0, Reset = 1, line_start = 0;
  logic [10:0] line_y = 0;
  logic [NC-1:0] ch_enable = 0, ch_mirror = 0;
  logic [NC*AW-1:0] ch_base = 0;
  logic [NC*11-1:0] ch_y = 0;
  logic [AW-1:0] avm_address;
  logic avm_chipselect, avm_read_n, avm_write_n;
  logic [DW/8-1:0] avm_byteenable_n;
  logic [DW-1:0] avm_readdata = 0;
  logic avm_readdatavalid = 0, avm_waitrequest = 0;
  logic [0:0] rd_ch = 0;
  logic [3:0] rd_idx = 0;
  logic [DW-1:0] rd_data;
  logic rd_valid, busy, overrun;
  int checks = 0, failures = 0;

  sprite_line_fetcher dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
    .ch_enable(ch_enable), .ch_base(ch_base), .ch_y(ch_y), .ch_mirror(ch_mirror),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read_n(avm_read_n),
    .avm_write_n(avm_write_n), .avm_byteenable_n(avm_byteenable_n), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {logic [AW-1:0] a; int due;} rd_t;
  rd_t mq[$];
  int cyc = 0, acc_cnt = 0, ov_cnt = 0;
  logic [AW-1:0] first_addr = 0, stall_addr = 0;
  logic stalled = 0, rand_wait = 0;

  always @(negedge Clk) begin
    int sz;
    logic wr;
    rd_t t;
    #1;
    cyc++;
    sz = mq.size();
    if (sz > 0 && mq[0].due <= cyc) begin
      avm_readdatavalid = 1;
      avm_readdata = DW'(mq[0].a);
      mq.delete(0);
    end else begin
      avm_readdatavalid = 0;
      avm_readdata = 0;
    end
    if (stalled && !Reset) begin
      chk("stall_read_n_held", avm_read_n, 0);
      chk("stall_addr_held", avm_address, stall_addr);
    end
    wr = rand_wait && ($urandom_range(0, 1) == 1);
    avm_waitrequest = wr;
    stalled = !avm_read_n && wr;
    stall_addr = avm_address;
    if (!avm_read_n && !wr && !Reset) begin
      chk("pending_over_max", sz + 1 > MAXP, 0);
      if (acc_cnt == 0) first_addr = avm_address;
      acc_cnt++;
      t.a = avm_address;
      t.due = cyc + LAT;
      mq.push_back(t);
    end
  end

  always @(negedge Clk) if (overrun === 1'b1) ov_cnt++;

  typedef struct {string nm; logic [DW-1:0] d; logic v;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic rq_v = 0, rq_v_d = 0;
  always @(posedge Clk) rq_v_d <= rq_v;
  always @(negedge Clk) if (rq_v_d) begin
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow: read output with no expected entry");
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_data"}, rd_data, e.d);
      chk({e.nm, "_valid"}, rd_valid, e.v);
    end
  end

  task automatic rd(input int ch, input int idx, input logic [DW-1:0] d, input logic v, input string nm);
    exp_t x;
    @(negedge Clk);
    rd_ch = 1'(ch);
    rd_idx = 4'(idx);
    rq_v = 1;
    x.nm = nm;
    x.d = d;
    x.v = v;
    sb.push_back(x);
  endtask

  task automatic rd_stop();
    @(negedge Clk);
    rq_v = 0;
  endtask

  task automatic pulse(input logic [NC-1:0] en, input logic [AW-1:0] b0, input logic [10:0] y0,
                       input logic [AW-1:0] b1, input logic [10:0] y1, input logic [NC-1:0] mir,
                       input logic [10:0] ly);
    @(negedge Clk);
    ch_enable = en;
    ch_base = {b1, b0};
    ch_y = {y1, y0};
    ch_mirror = mir;
    line_y = ly;
    line_start = 1;
    acc_cnt = 0;
    @(negedge Clk);
    line_start = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, n >= 3000, 0);
  endtask

  task automatic swap();
    pulse(0, 0, 0, 0, 0, 0, 0);
    wait_idle("swap");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic mir;
`ifdef SPRITE_FETCH_MIRROR_EN
    mir = 1;
`else
    mir = 0;
`endif
    repeat (3) @(negedge Clk);
    chk("rst_read_n", avm_read_n, 1);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("tie_write_n", avm_write_n, 1);
    chk("tie_be_n", avm_byteenable_n, 0);
    Reset = 0;

    pulse(2'b01, 'h100, 10, 0, 0, 0, 9);
    wait_idle("A");
    chk("A_accepts", acc_cnt, 16);
    chk("A_first_addr", first_addr, 'h100);
    swap();
    for (int k = 0; k < 16; k++) rd(0, k, 32'h100 + k, 1, "A_ch0");
    rd(1, 0, 0, 0, "A_ch1_0");
    rd(1, 9, 0, 0, "A_ch1_9");
    rd_stop();

    pulse(2'b01, 'h100, 10, 0, 0, 0, 40);
    wait_idle("B");
    chk("B_first_addr", first_addr, 'h2F0);
    chk("B_accepts", acc_cnt, 16);
    swap();
    rd(0, 0, 'h2F0, 1, "B_row31_0");
    rd(0, 15, 'h2FF, 1, "B_row31_15");
    rd_stop();

    pulse(2'b01, 'h100, 10, 0, 0, 0, 41);
    wait_idle("C");
    chk("C_accepts", acc_cnt, 0);
    swap();
    rd(0, 0, 0, 0, "C_row32_miss");
    rd_stop();

    pulse(2'b11, 'h100, 12, 'h2000, 11, 0, 10);
    wait_idle("D");
    chk("D_accepts", acc_cnt, 16);
    swap();
    rd(0, 0, 0, 0, "D_above_miss");
    rd(1, 3, 'h2003, 1, "D_ch1_3");
    rd(1, 15, 'h200F, 1, "D_ch1_15");
    rd_stop();
    chk("no_overrun_yet", ov_cnt, 0);

    rand_wait = 1;
    pulse(2'b01, 'h400, 0, 0, 0, 2'b01, 5);
    wait_idle("E");
    rand_wait = 0;
    chk("E_accepts", acc_cnt, 16);
    swap();
    for (int k = 0; k < 16; k++) rd(0, k, mir ? 32'h46F - k : 32'h460 + k, 1, "E_wait");
    rd_stop();

    pulse(2'b01, 'h100, 10, 0, 0, 2'b01, 9);
    wait_idle("F");
    swap();
    rd(0, 0, mir ? 'h10F : 'h100, 1, "F_mirror_0");
    rd(0, 15, mir ? 'h100 : 'h10F, 1, "F_mirror_15");
    rd_stop();

    pulse(2'b01, 'h100, 10, 0, 0, 0, 9);
    repeat (5) @(negedge Clk);
    line_y = 19;
    line_start = 1;
    @(negedge Clk);
    line_start = 0;
    rd(0, 0, 0, 0, "G_aborted_half_0");
    rd(0, 7, 0, 0, "G_aborted_half_7");
    rd_stop();
    wait_idle("G");
    chk("G_overrun_pulses", ov_cnt, 1);
    swap();
    chk("G_swap_no_overrun", ov_cnt, 1);
    for (int k = 0; k < 16; k++) rd(0, k, 32'h1A0 + k, 1, "G_new_line");
    rd_stop();

    pulse(2'b11, 'h100, 10, 'h2000, 10, 0, 9);
    n = 0;
    while (avm_read_n && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("H_issue_timeout", n >= 50, 0);
    Reset = 1;
    @(negedge Clk);
    chk("H_read_n", avm_read_n, 1);
    chk("H_cs", avm_chipselect, 0);
    chk("H_addr", avm_address, 0);
    chk("H_busy", busy, 0);
    chk("H_rd_valid", rd_valid, 0);
    Reset = 0;
    repeat (12) @(negedge Clk);
    rd(0, 0, 0, 0, "H_ch0");
    rd(1, 0, 0, 0, "H_ch1");
    rd_stop();
    pulse(2'b01, 'h100, 10, 0, 0, 0, 9);
    wait_idle("H_after");
    swap();
    rd(0, 5, 'h105, 1, "H_after_reset_fetch");
    rd_stop();

    repeat (3) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Multi-channel sprite scanline prefetcher between the VGA pixel pipeline and the Nios SDRAM controller's Avalon-MM slave port. It replaces direct per-pixel SDRAM addressing from the color mapper. On each `line_start` it fetches the next scanline's words for every enabled sprite channel into a ping-pong line buffer. The color mapper then reads the current line at a fixed 1-cycle latency, independent of SDRAM latency or `waitrequest` stalls.

## Interface
- `ADDR_W`, 25, Avalon word-address width.
- `DATA_W`, 32, Avalon data width; one buffer entry per word.
- `CHANNELS`, 2, number of independent sprite channels (1–8).
- `WORDS_PER_LINE`, 16, words per sprite row (power of 2).
- `SPRITE_H`, 32, sprite height in rows.
- `MAX_PENDING`, 4, maximum outstanding Avalon reads (1–15).

Ports:
- `Clk` in 1: system clock (50 MHz).
- `Reset` in 1: synchronous, active-high.
- `line_start` in 1: 1-cycle pulse at start of horizontal blank.
- `line_y` in 11: DrawY of the line now ending.
- `ch_enable` in CHANNELS: per-channel enable, sampled at `line_start`.
- `ch_base` in CHANNELS*ADDR_W: sprite image base word address, channel c at bits [c*ADDR_W +: ADDR_W].
- `ch_y` in CHANNELS*11: sprite top row on screen.
- `ch_mirror` in CHANNELS: horizontal flip (see Configuration).
- `avm_address` out ADDR_W: read word address.
- `avm_chipselect` out 1: high while a read is asserted.
- `avm_read_n` out 1: active-low read request.
- `avm_write_n` out 1: tied 1.
- `avm_byteenable_n` out DATA_W/8: tied 0.
- `avm_readdata` in DATA_W: returned data.
- `avm_readdatavalid` in 1: return strobe.
- `avm_waitrequest` in 1: slave stall.
- `rd_ch` in $clog2(CHANNELS): display-side channel select.
- `rd_idx` in $clog2(WORDS_PER_LINE): display-side word index.
- `rd_data` out DATA_W: buffered word; 0 when the line is not valid.
- `rd_valid` out 1: selected channel hit on the current line.
- `busy` out 1: fetch in progress.
- `overrun` out 1: 1-cycle pulse when `line_start` arrives while busy.

## Operation
- Buffer: 2 halves × CHANNELS × WORDS_PER_LINE words, plus a valid bit per half per channel. `disp_sel` selects the display half. Writes always go to the other half.
- `line_start`:
  - toggles `disp_sel`;
  - clears all valid bits in the new write half;
  - latches `ch_*` and `next_y = line_y + 1` (11-bit wrap);
  - starts the FSM at channel 0.
- FSM states:
  - IDLE: waits for `line_start`.
  - SETUP: computes `row = next_y - ch_y[c]`. A hit requires `ch_enable[c]`, `next_y >= ch_y[c]` and `row < SPRITE_H`. Miss → NEXT; hit → ISSUE with `i=0`.
  - ISSUE: asserts `avm_address = ch_base + row*WORDS_PER_LINE + i` (truncated to ADDR_W) while `pending < MAX_PENDING`. After the last word is accepted → DRAIN.
  - DRAIN: waits until `pending == 0`, sets the valid bit for channel c → NEXT.
  - NEXT: `c+1`; after the last channel → IDLE.
- Avalon handshake:
  - A read is accepted on a cycle with `avm_read_n=0 && !avm_waitrequest`.
  - Address and `avm_read_n` are held stable while `waitrequest` is high.
  - `i` advances only on accept.
- Pending counter: +1 on accept, −1 on `readdatavalid`; both in the same cycle leaves it unchanged. The counter never exceeds MAX_PENDING. A `readdatavalid` with `pending == 0` is ignored.
- Return data is written in order to write-half entry `w` (see Configuration); `w` increments per `readdatavalid`.
- `line_start` while busy:
  - pulse `overrun`;
  - stop issuing immediately;
  - still perform the buffer swap and clear;
  - drop remaining returns for the aborted line (counted, not written);
  - restart SETUP at channel 0 once `pending == 0`.

  Valid bits from the aborted line are never set.
- `line_start` in IDLE: normal, no overrun.

## Timing
- Reset values: `avm_read_n=1`, `avm_chipselect=0`, `avm_address=0`, `busy=0`, `overrun=0`, `rd_data=0`, `rd_valid=0`, `disp_sel=0`, all valid bits 0, pending=0, FSM IDLE.
- `rd_data` and `rd_valid` are registered, 1 cycle after `rd_ch`/`rd_idx`. A `disp_sel` toggle takes effect on reads sampled in the cycle after `line_start`.
- First read is asserted 2 cycles after `line_start` (SETUP, then ISSUE).
- With `waitrequest=0`, issue rate is 1 word/cycle until MAX_PENDING is outstanding.
- `busy` is high from the cycle after `line_start` until the cycle after IDLE is re-entered.
- Reset mid-fetch: all state returns to reset values next cycle; late `readdatavalid` is ignored.

## Configuration
- `SPRITE_FETCH_MIRROR_EN`:
  - Defined: when `ch_mirror[c]` is set, the k-th returned word is stored at `w = WORDS_PER_LINE-1-k` (word-granular flip).
  - Undefined: `ch_mirror` is ignored and `w = k` always.

## Test plan
- **Single channel hit.** CHANNELS=2, ch0 enabled, base=0x100, ch_y=10, line_y=9, SDRAM model returns address as data. After the next `line_start`, read ch0 idx 0..15 → 0x100..0x10F, `rd_valid=1`; ch1 → `rd_data=0`, `rd_valid=0`.
- **Row offset and miss boundaries.**
  - line_y=40, ch_y=10 → row 31, first address base+496.
  - line_y=41 → miss, valid 0.
  - ch_y=12, line_y=10 → miss.
- **Waitrequest and backpressure.** Random `waitrequest` 50% plus 5-cycle read latency, MAX_PENDING=4. Address stays stable while stalled, pending never exceeds 4, and all 16 words are stored in order.
- **Overrun.** `line_start` issued 6 cycles into a fetch. `overrun` pulses once, late returns are not written, the new line fills correctly, and the aborted half's valid bit stays 0.
- **Mirror.** With `SPRITE_FETCH_MIRROR_EN` and `ch_mirror[0]=1`, idx 0 → 0x10F and idx 15 → 0x100. Without the macro, same stimulus gives idx 0 → 0x100.
- **Reset mid-fetch.** `Reset` during ISSUE: next cycle `avm_read_n=1`, `busy=0`, `rd_valid=0` on all channels.
